// File: rtl/id_link_pkg.sv
// Items shared by the ID link transmitter and the IdReceiver decoder.
package id_link_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hD5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    GAP    = 3'd4
  } tx_state_t;

  // IEEE 802.3 Manchester: 0 = high then low, 1 = low then high.
  // phase selects the half: 0 = first half, 1 = second half.
  function automatic logic manchester_half(input logic bit_val, input logic phase);
    return ~(bit_val ^ phase);
  endfunction

  // Counter width for a 0..n-1 count, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/id_transmitter_bit_timer.sv
// Half-bit timer: counts HALF_CYCLES per half and toggles a phase flag.
// Next-cycle values are exposed so the owner can register its outputs
// against the position the line will be at in the following cycle.
module bit_timer
  import id_link_pkg::*;
#(
  parameter int HALF_CYCLES = 250
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             restart,
  output logic [cnt_width(HALF_CYCLES)-1:0] half_cnt_nxt,
  output logic                             phase_nxt,
  output logic                             bit_end
);

  localparam int HW = cnt_width(HALF_CYCLES);

  logic [HW-1:0] half_cnt;
  logic          phase;
  logic          half_end;

  // Next count/phase: restart parks at the start of a bit, otherwise wrap per half.
  always_comb begin
    half_end     = (half_cnt == HW'(HALF_CYCLES - 1));
    bit_end      = half_end && phase;
    half_cnt_nxt = half_cnt + HW'(1);
    phase_nxt    = phase;
    if (restart) begin
      half_cnt_nxt = '0;
      phase_nxt    = 1'b0;
    end else if (half_end) begin
      half_cnt_nxt = '0;
      phase_nxt    = ~phase;
    end
  end

  // Counter state.
  always_ff @(posedge clk) begin
    if (reset) begin
      half_cnt <= '0;
      phase    <= 1'b0;
    end else begin
      half_cnt <= half_cnt_nxt;
      phase    <= phase_nxt;
    end
  end

endmodule

// File: rtl/id_transmitter.sv
// ID frame transmitter: SYNC byte, ID (MSB first) and even parity,
// Manchester coded on tx_out, followed by an idle gap.
module id_transmitter
  import id_link_pkg::*;
#(
  parameter int         ID_WIDTH   = 32,
  parameter int         BIT_CYCLES = 500,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  parameter int         GAP_BITS   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ID_WIDTH-1:0] id_in,
  input  logic                id_valid,
  output logic                id_ready,
  output logic                tx_out,
  output logic                busy,
  output logic                frame_done
);

  localparam int HALF     = BIT_CYCLES / 2;
  localparam int HW       = cnt_width(HALF);
  localparam int FW       = 9 + ID_WIDTH;
  localparam int MAX_WG   = (ID_WIDTH > GAP_BITS) ? ID_WIDTH : GAP_BITS;
  localparam int MAX_BITS = (MAX_WG > 8) ? MAX_WG : 8;
  localparam int BCW      = $clog2(MAX_BITS + 1);

  if (BIT_CYCLES < 2 || (BIT_CYCLES % 2) != 0) begin : g_bad_bit_cycles
    $error("id_transmitter: BIT_CYCLES must be even and >= 2");
  end
  if (ID_WIDTH < 1) begin : g_bad_id_width
    $error("id_transmitter: ID_WIDTH must be >= 1");
  end
  if (GAP_BITS < 1) begin : g_bad_gap_bits
    $error("id_transmitter: GAP_BITS must be >= 1");
  end

  tx_state_t      state, nxt_state;
  logic [BCW-1:0] bit_cnt, nxt_bit_cnt;
  logic [FW-1:0]  frame_sr, nxt_sr;
  logic           restart;
  logic [HW-1:0]  half_cnt_nxt;
  logic           phase_nxt;
  logic           bit_end;
  logic           line_active;
  logic           tx_nxt;
  logic           done_nxt;

  bit_timer #(
    .HALF_CYCLES(HALF)
  ) u_bit_timer (
    .clk         (clk),
    .reset       (reset),
    .restart     (restart),
    .half_cnt_nxt(half_cnt_nxt),
    .phase_nxt   (phase_nxt),
    .bit_end     (bit_end)
  );

  // Frame sequencing; the whole frame lives in one shift register whose MSB is the current line bit.
  always_comb begin
    nxt_state   = state;
    nxt_bit_cnt = bit_cnt;
    nxt_sr      = frame_sr;
    restart     = 1'b0;
    unique case (state)
      IDLE: begin
        restart = 1'b1;
        if (id_valid && id_ready) begin
          nxt_state   = SYNC;
          nxt_bit_cnt = '0;
          nxt_sr      = {SYNC_BYTE, id_in, ^id_in};
        end
      end
      SYNC: begin
        if (bit_end) begin
          nxt_sr = {frame_sr[FW-2:0], 1'b0};
          if (bit_cnt == BCW'(7)) begin
            nxt_state   = DATA;
            nxt_bit_cnt = '0;
          end else begin
            nxt_bit_cnt = bit_cnt + BCW'(1);
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          nxt_sr = {frame_sr[FW-2:0], 1'b0};
          if (bit_cnt == BCW'(ID_WIDTH - 1)) begin
            nxt_state   = PARITY;
            nxt_bit_cnt = '0;
          end else begin
            nxt_bit_cnt = bit_cnt + BCW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          nxt_state   = GAP;
          nxt_bit_cnt = '0;
        end
      end
      GAP: begin
        if (bit_end) begin
          if (bit_cnt == BCW'(GAP_BITS - 1)) begin
            nxt_state   = IDLE;
            nxt_bit_cnt = '0;
          end else begin
            nxt_bit_cnt = bit_cnt + BCW'(1);
          end
        end
      end
      default: begin
        nxt_state   = IDLE;
        nxt_bit_cnt = '0;
      end
    endcase

    line_active = (nxt_state == SYNC) || (nxt_state == DATA) || (nxt_state == PARITY);
    tx_nxt      = line_active ? manchester_half(nxt_sr[FW-1], phase_nxt) : 1'b0;
    done_nxt    = (nxt_state == PARITY) && phase_nxt && (half_cnt_nxt == HW'(HALF - 1));
  end

  // State and registered outputs, all derived from the next-cycle position.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      frame_sr   <= '0;
      tx_out     <= 1'b0;
      id_ready   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      bit_cnt    <= nxt_bit_cnt;
      frame_sr   <= nxt_sr;
      tx_out     <= tx_nxt;
      id_ready   <= (nxt_state == IDLE);
      busy       <= (nxt_state != IDLE);
      frame_done <= done_nxt;
    end
  end

endmodule
